cu_group_arbiter: RTL and testbench
===================================

// Module: cu_group_arbiter
// PURPOSE
//  Parametrised N-channel front end between NUM_CU compute units and the single AFU command/response path.
//  Round-robin arbitrates CU commands into one registered command stream and stamps each with a routing tag.
//  Tracks per-CU outstanding credits, routes responses back by tag and aggregates CU done into one handshaked group done.
//  Sits between cu_control instances and afu_control, replacing the one-CU point-to-point hookup.
// PARAMETERS
//  NUM_CU          4   number of CU channels, 2..16
//  CMD_W           64  command payload width per channel
//  SEQ_W           6   per-channel sequence field width; TAG_W = SEQ_W + $clog2(NUM_CU)
//  MAX_OUTSTANDING 16  max unanswered commands per CU, 1..2**SEQ_W
// PORTS
//  clock            in   1              sole clock, all logic posedge
//  rst_in           in   1              synchronous, active-high reset
//  enabled_in       in   1              job running; arbitration only while high
//  cu_cmd_valid_in  in   NUM_CU         per-CU command request
//  cu_cmd_in        in   NUM_CU*CMD_W   per-CU payload, channel i at [i*CMD_W +: CMD_W]
//  cu_cmd_ready_out out  NUM_CU         one-hot grant; command i taken when valid&ready
//  cmd_valid_out    out  1              registered command valid
//  cmd_out          out  CMD_W          registered payload
//  cmd_tag_out      out  TAG_W          {seq, cu_index}; cu_index in low bits
//  cmd_ready_in     in   1              downstream accepts when valid&ready
//  rsp_valid_in     in   1              response strobe
//  rsp_tag_in       in   TAG_W          tag of the answered command
//  rsp_code_in      in   8              response code, passed through
//  cu_rsp_valid_out out  NUM_CU         one-hot routed response, registered
//  cu_rsp_code_out  out  8              routed response code
//  cu_done_in       in   NUM_CU         per-CU done level
//  group_done_out   out  1              all CUs done and fully drained
//  done_ack_in      in   1              clears group_done_out
//  tag_error_out    out  1              sticky: response to channel with zero outstanding, or index >= NUM_CU
//  outstanding_out  out  NUM_CU*8       per-CU outstanding count, zero-extended
//  grant_count_out  out  NUM_CU*32      per-CU grant statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer 0; seq counters 0; outstanding 0; FSM IDLE. Reset mid-operation drops in-flight
//   commands and the output register with no response generated.
//  Eligible(i) = cu_cmd_valid_in[i] & outstanding[i] < MAX_OUTSTANDING & enabled_in & FSM in RUN or DRAIN.
//  Grant: combinational round-robin over eligible channels, starting at rr pointer. Issued only when the output register
//   is empty or being accepted this cycle (cmd_valid_out & cmd_ready_in), so full throughput is 1 cmd/cycle.
//  On grant i: cmd_out/cmd_tag_out load next edge (latency 1); seq[i] += 1, wrapping mod 2**SEQ_W; outstanding[i] += 1;
//   rr pointer = (i+1) mod NUM_CU. No eligible channel: pointer holds.
//  cmd_valid_out holds with stable payload/tag until accepted; no combinational path from cmd_ready_in to cmd_out.
//  Response: idx = rsp_tag_in low bits. Valid idx with outstanding[idx] > 0: cu_rsp_valid_out[idx] pulses 1 cycle
//   later with the code, and outstanding[idx] -= 1. Otherwise the response is dropped and tag_error_out sets
//   (cleared only by reset).
//  Grant and response on the same channel in the same cycle: outstanding unchanged.
//  At MAX_OUTSTANDING a channel's ready stays low and it is skipped by arbitration; it becomes eligible the cycle after
//   its count drops.
//  FSM:
//   IDLE ->RUN on enabled_in.
//   RUN  ->DRAIN when &cu_done_in.
//   DRAIN->DONE when all outstanding == 0 and !cmd_valid_out.
//   DONE ->IDLE on done_ack_in.
//   group_done_out = (state == DONE), registered.
//   enabled_in low in RUN/DRAIN: arbitration stops and the drain still completes.
//   Done and ack arriving in the same cycle as DONE entry: the ack is honoured on the next cycle only.
// CONFIGURATION
//  CU_GROUP_STATS_EN defined: per-CU 32-bit grant counter, +1 on each grant, saturates at 32'hFFFF_FFFF,
//   cleared by reset and on the IDLE->RUN transition. Not defined: grant_count_out tied to 0 and no counters built.
//   All other behaviour is identical in both builds.
// TESTING
//  Single CU0 request, cmd_ready_in=1 -> cmd_valid_out next cycle, tag = {6'd0,2'd0}; second CU0 cmd tag = {6'd1,2'd0}.
//  All 4 CUs valid continuously, ready=1 -> grants 0,1,2,3,0,... one per cycle; outstanding = 1 each after 4 cycles.
//  CU2 issues 16 commands with no responses -> ready[2] low; one rsp tag idx 2 -> ready[2] high the following cycle.
//  Response with idx 3 while outstanding[3]=0 -> no cu_rsp_valid_out pulse, tag_error_out=1 and stays 1.
//  cmd_ready_in low 5 cycles -> cmd_out/cmd_tag_out stable and no new grants; same-cycle grant+rsp on CU1 -> count unchanged.
//  cu_done_in=4'hF with 2 outstanding -> DRAIN; after 2 responses group_done_out=1; done_ack_in -> 0 and IDLE.

Source files
------------

// File: rtl/cu_group_arbiter.sv
// N-channel CU front end: round-robin command arbitration with routing tags, per-CU credits,
// tag-routed responses and group-done aggregation. Optional grant statistics: CU_GROUP_STATS_EN.
module cu_group_arbiter #(
  parameter int NUM_CU          = 4,
  parameter int CMD_W           = 64,
  parameter int SEQ_W           = 6,
  parameter int MAX_OUTSTANDING = 16,
  localparam int IDX_W          = $clog2(NUM_CU),
  localparam int TAG_W          = SEQ_W + IDX_W
) (
  input  logic                   clock,
  input  logic                   rst_in,
  input  logic                   enabled_in,
  input  logic [NUM_CU-1:0]      cu_cmd_valid_in,
  input  logic [NUM_CU*CMD_W-1:0] cu_cmd_in,
  output logic [NUM_CU-1:0]      cu_cmd_ready_out,
  output logic                   cmd_valid_out,
  output logic [CMD_W-1:0]       cmd_out,
  output logic [TAG_W-1:0]       cmd_tag_out,
  input  logic                   cmd_ready_in,
  input  logic                   rsp_valid_in,
  input  logic [TAG_W-1:0]       rsp_tag_in,
  input  logic [7:0]             rsp_code_in,
  output logic [NUM_CU-1:0]      cu_rsp_valid_out,
  output logic [7:0]             cu_rsp_code_out,
  input  logic [NUM_CU-1:0]      cu_done_in,
  output logic                   group_done_out,
  input  logic                   done_ack_in,
  output logic                   tag_error_out,
  output logic [NUM_CU*8-1:0]    outstanding_out,
  output logic [NUM_CU*32-1:0]   grant_count_out
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic                group_done_q;
  logic                tag_error_q;
  logic [IDX_W-1:0]    rr_q;
  logic [CNT_W-1:0]    outst_q [NUM_CU];
  logic [SEQ_W-1:0]    seq_q [NUM_CU];
  logic                cmd_valid_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [TAG_W-1:0]    tag_q;
  logic [NUM_CU-1:0]   rsp_valid_q;
  logic [7:0]          rsp_code_q;

  logic                arb_en;
  logic [NUM_CU-1:0]   elig;
  logic [NUM_CU-1:0]   grant_vec;
  logic [NUM_CU-1:0]   rsp_hit;
  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    rsp_idx;
  logic                rsp_ok;
  logic                all_idle;
  logic                unused_seq_bits;

  // A grant may only be issued when the output register is free this cycle.
  assign arb_en  = enabled_in & (state_q == RUN || state_q == DRAIN) & (~cmd_valid_q | cmd_ready_in);
  assign rsp_idx = rsp_tag_in[IDX_W-1:0];
  assign rsp_ok  = |rsp_hit;
  assign unused_seq_bits = ^rsp_tag_in[TAG_W-1:IDX_W];

  generate
    for (genvar gi = 0; gi < NUM_CU; gi++) begin : g_chan
      assign elig[gi]    = arb_en & cu_cmd_valid_in[gi] & (outst_q[gi] < MAX_CNT);
      assign rsp_hit[gi] = rsp_valid_in & (rsp_idx == IDX_W'(gi)) & (outst_q[gi] != '0);
      assign outstanding_out[gi*8 +: 8] = 8'(outst_q[gi]);

      always_ff @(posedge clock) begin
        if (rst_in) begin
          outst_q[gi] <= '0;
          seq_q[gi]   <= '0;
        end else begin
          if (grant_vec[gi] && !rsp_hit[gi]) outst_q[gi] <= outst_q[gi] + 1'b1;
          else if (!grant_vec[gi] && rsp_hit[gi]) outst_q[gi] <= outst_q[gi] - 1'b1;
          if (grant_vec[gi]) seq_q[gi] <= seq_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    for (int k = 0; k < NUM_CU; k++) begin
      if (!grant_found && elig[(int'(rr_q) + k) % NUM_CU]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr_q) + k) % NUM_CU);
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    all_idle = ~cmd_valid_q;
    for (int k = 0; k < NUM_CU; k++) begin
      if (outst_q[k] != '0) all_idle = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst_in) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      tag_q       <= '0;
      rr_q        <= '0;
      rsp_valid_q <= '0;
      rsp_code_q  <= '0;
      tag_error_q <= 1'b0;
    end else begin
      if (grant_found) begin
        cmd_valid_q <= 1'b1;
        cmd_q       <= cu_cmd_in[grant_idx*CMD_W +: CMD_W];
        tag_q       <= {seq_q[grant_idx], grant_idx};
        rr_q        <= (grant_idx == IDX_W'(NUM_CU - 1)) ? '0 : grant_idx + 1'b1;
      end else if (cmd_ready_in) begin
        cmd_valid_q <= 1'b0;
      end
      rsp_valid_q <= rsp_hit;
      if (rsp_ok) rsp_code_q <= rsp_code_in;
      if (rsp_valid_in && !rsp_ok) tag_error_q <= 1'b1;
    end
  end

  // Ack is only looked at in DONE, so an ack coinciding with DONE entry waits a cycle.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      state_q      <= IDLE;
      group_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (enabled_in) state_q <= RUN;
        RUN:   if (&cu_done_in) state_q <= DRAIN;
        DRAIN: if (all_idle) begin
          state_q      <= DONE;
          group_done_q <= 1'b1;
        end
        DONE:  if (done_ack_in) begin
          state_q      <= IDLE;
          group_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CU_GROUP_STATS_EN
  logic start_run;
  assign start_run = (state_q == IDLE) & enabled_in;

  generate
    for (genvar gi = 0; gi < NUM_CU; gi++) begin : g_stats
      logic [31:0] cnt_q;
      always_ff @(posedge clock) begin
        if (rst_in || start_run) cnt_q <= '0;
        else if (grant_vec[gi] && cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
      end
      assign grant_count_out[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`else
  assign grant_count_out = '0;
`endif

  assign cu_cmd_ready_out = grant_vec;
  assign cmd_valid_out    = cmd_valid_q;
  assign cmd_out          = cmd_q;
  assign cmd_tag_out      = tag_q;
  assign cu_rsp_valid_out = rsp_valid_q;
  assign cu_rsp_code_out  = rsp_code_q;
  assign group_done_out   = group_done_q;
  assign tag_error_out    = tag_error_q;

endmodule

// File: tb/tb_cu_group_arbiter.sv
// Randomized bench for cu_group_arbiter against a transaction-level model of credits, tags and group done.
module tb_cu_group_arbiter;
  localparam int N  = 4;
  localparam int CW = 64;
  localparam int MO = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              rst_in, enabled_in, cmd_ready_in, rsp_valid_in, done_ack_in;
  logic [N-1:0]      cu_cmd_valid_in, cu_done_in;
  logic [N*CW-1:0]   cu_cmd_in;
  logic [7:0]        rsp_tag_in, rsp_code_in;
  logic [N-1:0]      cu_cmd_ready_out, cu_rsp_valid_out;
  logic              cmd_valid_out, group_done_out, tag_error_out;
  logic [CW-1:0]     cmd_out;
  logic [7:0]        cmd_tag_out, cu_rsp_code_out;
  logic [N*8-1:0]    outstanding_out;
  logic [N*32-1:0]   grant_count_out;

  cu_group_arbiter dut (
    .clock(clock), .rst_in(rst_in), .enabled_in(enabled_in),
    .cu_cmd_valid_in(cu_cmd_valid_in), .cu_cmd_in(cu_cmd_in), .cu_cmd_ready_out(cu_cmd_ready_out),
    .cmd_valid_out(cmd_valid_out), .cmd_out(cmd_out), .cmd_tag_out(cmd_tag_out), .cmd_ready_in(cmd_ready_in),
    .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_code_in(rsp_code_in),
    .cu_rsp_valid_out(cu_rsp_valid_out), .cu_rsp_code_out(cu_rsp_code_out),
    .cu_done_in(cu_done_in), .group_done_out(group_done_out), .done_ack_in(done_ack_in),
    .tag_error_out(tag_error_out), .outstanding_out(outstanding_out), .grant_count_out(grant_count_out)
  );

  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t     m_st;
  int          m_rr, m_rsp_cu, m_tag, cyc;
  int          m_seq [N];
  int          m_out [N];
  longint      m_cnt [N];
  bit          m_vld, m_err, m_gd, m_just_rst;
  logic [CW-1:0] m_cmd;
  logic [7:0]  m_code;
  int          total = 0;
  int          bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = M_IDLE; m_rr = 0; m_vld = 0; m_cmd = '0; m_tag = 0; m_rsp_cu = -1;
    m_code = '0; m_err = 0; m_gd = 0; m_just_rst = 1;
    for (int i = 0; i < N; i++) begin m_seq[i] = 0; m_out[i] = 0; m_cnt[i] = 0; end
  endfunction

  // Which channel the spec's round-robin rule picks this cycle, or -1.
  function automatic int model_grant();
    if (!(enabled_in && (m_st == M_RUN || m_st == M_DRAIN) && (!m_vld || cmd_ready_in))) return -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (cu_cmd_valid_in[c] && m_out[c] < MO) return c;
    end
    return -1;
  endfunction

  function automatic int total_out();
    int s = 0;
    for (int i = 0; i < N; i++) s += m_out[i];
    return s;
  endfunction

  function automatic void model_step(input int g);
    int idx;
    bit ok;
    if (rst_in) begin model_reset(); return; end
    m_just_rst = 0;
    idx = int'(rsp_tag_in[1:0]);
    ok  = rsp_valid_in && m_out[idx] > 0;
    case (m_st)
      M_IDLE:  if (enabled_in) begin
        m_st = M_RUN;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
      M_RUN:   if (cu_done_in == 4'hF) m_st = M_DRAIN;
      M_DRAIN: if (!m_vld && total_out() == 0) m_st = M_DONE;
      M_DONE:  if (done_ack_in) m_st = M_IDLE;
      default: m_st = M_IDLE;
    endcase
    m_gd = (m_st == M_DONE);
    if (rsp_valid_in && !ok) m_err = 1;
    m_rsp_cu = ok ? idx : -1;
    if (ok) m_code = rsp_code_in;
    if (g >= 0) begin
      m_vld = 1;
      m_cmd = cu_cmd_in[g*CW +: CW];
      m_tag = m_seq[g] * N + g;
      m_seq[g] = (m_seq[g] + 1) % 64;
      m_out[g]++;
      m_rr = (g + 1) % N;
      if (m_cnt[g] < 64'hFFFF_FFFF) m_cnt[g]++;
    end else if (cmd_ready_in) begin
      m_vld = 0;
    end
    if (ok) m_out[idx]--;
  endfunction

  task automatic check_outputs();
    logic [N-1:0]    e_rsp;
    logic [N*8-1:0]  e_out;
    logic [N*32-1:0] e_cnt;
    e_rsp = '0;
    if (m_rsp_cu >= 0) e_rsp[m_rsp_cu] = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_out[i*8 +: 8] = 8'(m_out[i]);
`ifdef CU_GROUP_STATS_EN
      e_cnt[i*32 +: 32] = 32'(m_cnt[i]);
`else
      e_cnt[i*32 +: 32] = 32'd0;
`endif
    end
    check_eq("cmd_valid", 128'(cmd_valid_out), 128'(m_vld));
    if (m_vld || m_just_rst) begin
      check_eq("cmd_out", 128'(cmd_out), 128'(m_cmd));
      check_eq("cmd_tag", 128'(cmd_tag_out), 128'(m_tag));
    end
    check_eq("rsp_valid", 128'(cu_rsp_valid_out), 128'(e_rsp));
    if (m_rsp_cu >= 0) check_eq("rsp_code", 128'(cu_rsp_code_out), 128'(m_code));
    check_eq("group_done", 128'(group_done_out), 128'(m_gd));
    check_eq("tag_error", 128'(tag_error_out), 128'(m_err));
    check_eq("outstanding", 128'(outstanding_out), 128'(e_out));
    check_eq("grant_count", 128'(grant_count_out), 128'(e_cnt));
  endtask

  task automatic step();
    int g;
    logic [N-1:0] e_rdy;
    #1;
    g = model_grant();
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    check_eq("ready", 128'(cu_cmd_ready_out), 128'(e_rdy));
    model_step(g);
    if (g >= 0) $display("cyc %0d grant cu=%0d tag=%02h out=%0d", cyc, g, m_tag, m_out[g]);
    else if (m_rsp_cu >= 0) $display("cyc %0d rsp cu=%0d code=%02h", cyc, m_rsp_cu, m_code);
    @(posedge clock);
    #1;
    check_outputs();
    cyc++;
    @(negedge clock);
    for (int i = 0; i < N; i++) cu_cmd_in[i*CW +: CW] = {$urandom, $urandom};
    rsp_valid_in = 1'b0;
  endtask

  // Pick a response for a channel the model still owes, with probability pct.
  task automatic pick_rsp(input int pct);
    int c;
    rsp_valid_in = 1'b0;
    if (total_out() > 0 && int'($urandom_range(99)) < pct) begin
      do c = int'($urandom_range(N - 1)); while (m_out[c] == 0);
      rsp_valid_in = 1'b1;
      rsp_tag_in   = {6'($urandom), 2'(c)};
      rsp_code_in  = 8'($urandom);
    end
  endtask

  initial begin
    int n;
    cyc = 0;
    rst_in = 1; enabled_in = 0; cmd_ready_in = 1; rsp_valid_in = 0; done_ack_in = 0;
    cu_cmd_valid_in = '0; cu_done_in = '0; cu_cmd_in = '0; rsp_tag_in = '0; rsp_code_in = '0;
    model_reset();
    @(negedge clock);
    repeat (2) step();
    rst_in = 0;

    enabled_in = 1; cu_cmd_valid_in = 4'b0001;
    repeat (4) step();
    cu_cmd_valid_in = 4'hF;
    repeat (8) step();
    cu_cmd_valid_in = 4'b0100;
    repeat (20) step();
    rsp_valid_in = 1; rsp_tag_in = 8'h02; rsp_code_in = 8'h5A;
    repeat (3) step();

    cu_cmd_valid_in = '0;
    n = 0;
    while ((total_out() > 0 || m_vld) && n < 300) begin pick_rsp(100); step(); n++; end
    check_eq("drained", 128'(outstanding_out), 128'(0));

    rsp_valid_in = 1; rsp_tag_in = 8'h03; rsp_code_in = 8'hEE;
    repeat (3) step();

    cmd_ready_in = 0; cu_cmd_valid_in = 4'hF;
    repeat (5) step();
    cmd_ready_in = 1; cu_cmd_valid_in = 4'b0010;
    step();
    rsp_valid_in = 1; rsp_tag_in = 8'h01; rsp_code_in = 8'h11;
    step();

    for (int i = 0; i < 400; i++) begin
      cu_cmd_valid_in = 4'($urandom);
      cmd_ready_in    = ($urandom_range(99) < 75);
      enabled_in      = ($urandom_range(99) < 95);
      rst_in          = ($urandom_range(99) < 1);
      pick_rsp(50);
      if ($urandom_range(99) < 2) begin rsp_valid_in = 1; rsp_tag_in = 8'($urandom); end
      step();
    end
    rst_in = 0; enabled_in = 1; cmd_ready_in = 1; cu_cmd_valid_in = '0;
    n = 0;
    while ((total_out() > 0 || m_vld || m_st != M_RUN) && n < 300) begin pick_rsp(100); step(); n++; end

    cu_cmd_valid_in = 4'b0001;
    repeat (2) step();
    cu_cmd_valid_in = '0; cu_done_in = 4'hF;
    n = 0;
    while (m_st != M_DONE && n < 50) begin pick_rsp(60); step(); n++; end
    check_eq("group_done_set", 128'(group_done_out), 128'(1));
    step();
    done_ack_in = 1;
    step();
    done_ack_in = 0;
    check_eq("group_done_ack", 128'(group_done_out), 128'(0));
    cu_done_in = '0;
    repeat (3) step();

    cu_done_in = 4'hF; done_ack_in = 1;
    repeat (10) step();
    done_ack_in = 0; cu_done_in = '0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
